deser_rr_arbiter: RTL and testbench

Round-robin scheduler that shares one serial-to-parallel deserializer between N_REQ serial sources. Grants one source at a time and forwards its bit stream to the deserializer for exactly DATA_W valid bits. Reports the source ID of each completed word. Runs a watchdog that aborts a stalled transfer and resynchronises the deserializer through its synchronous reset.

---
 rtl/deser_rr_arbiter.sv | 171 +++++++++++++++++
 tb/tb_deser_rr_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/deser_rr_arbiter.sv
// Round-robin scheduler sharing one serial-to-parallel deserializer among N_REQ
// serial sources, with a per-grant watchdog that aborts stalled transfers.
module deser_rr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic [N_REQ-1:0]         req_i,
  input  logic [N_REQ-1:0]         data_i,
  input  logic [N_REQ-1:0]         data_val_i,
  output logic [N_REQ-1:0]         gnt_o,
  output logic [$clog2(N_REQ)-1:0] owner_o,
  output logic                     deser_data_o,
  output logic                     deser_data_val_o,
  output logic                     deser_srst_o,
  output logic                     word_done_o,
  output logic [$clog2(N_REQ)-1:0] word_src_o,
  output logic                     abort_o
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int BIT_W = $clog2(DATA_W);
  localparam int TO_W  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;

  state_t             state_reg, state_next;
  logic [ID_W-1:0]    owner_reg, owner_next;
  logic [ID_W-1:0]    last_reg, last_next;
  logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [TO_W-1:0]    to_cnt_reg, to_cnt_next;
  logic [N_REQ-1:0]   gnt_reg, gnt_next;
  logic               deser_data_reg, deser_data_next;
  logic               deser_val_reg, deser_val_next;
  logic               deser_srst_reg, deser_srst_next;
  logic               word_done_reg, word_done_next;
  logic [ID_W-1:0]    word_src_reg, word_src_next;
  logic               abort_reg, abort_next;

  // Requests rotated so that bit 0 is the source right after the last grantee.
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic               pick_valid;
  int                 pick_off;
  int                 pick_idx;
  logic [ID_W-1:0]    pick;
  logic [N_REQ-1:0]   pick_onehot;

  assign req_dbl = {req_i, req_i};
  assign req_rot = N_REQ'(req_dbl >> (int'(last_reg) + 1));

  always_comb begin
    pick_valid = 1'b0;
    pick_off   = 0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!pick_valid && req_rot[j]) begin
        pick_off   = j;
        pick_valid = 1'b1;
      end
    end
    pick_idx = int'(last_reg) + 1 + pick_off;
    if (pick_idx >= N_REQ) begin
      pick_idx = pick_idx - N_REQ;
    end
    pick = ID_W'(pick_idx);
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
    assign pick_onehot[gi] = (pick == ID_W'(gi));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg      <= IDLE;
      owner_reg      <= '0;
      last_reg       <= ID_W'(N_REQ - 1);
      bit_cnt_reg    <= '0;
      to_cnt_reg     <= '0;
      gnt_reg        <= '0;
      deser_data_reg <= 1'b0;
      deser_val_reg  <= 1'b0;
      deser_srst_reg <= 1'b0;
      word_done_reg  <= 1'b0;
      word_src_reg   <= '0;
      abort_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_reg       <= last_next;
      bit_cnt_reg    <= bit_cnt_next;
      to_cnt_reg     <= to_cnt_next;
      gnt_reg        <= gnt_next;
      deser_data_reg <= deser_data_next;
      deser_val_reg  <= deser_val_next;
      deser_srst_reg <= deser_srst_next;
      word_done_reg  <= word_done_next;
      word_src_reg   <= word_src_next;
      abort_reg      <= abort_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_next       = last_reg;
    bit_cnt_next    = bit_cnt_reg;
    to_cnt_next     = to_cnt_reg;
    gnt_next        = gnt_reg;
    deser_data_next = deser_data_reg;
    deser_val_next  = 1'b0;
    deser_srst_next = 1'b0;
    word_done_next  = 1'b0;
    word_src_next   = word_src_reg;
    abort_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          owner_next   = pick;
          last_next    = pick;
          gnt_next     = pick_onehot;
          bit_cnt_next = '0;
          to_cnt_next  = '0;
          state_next   = BUSY;
        end
      end
      BUSY: begin
        deser_data_next = data_i[owner_reg];
        deser_val_next  = data_val_i[owner_reg];
        if (data_val_i[owner_reg]) begin
          to_cnt_next = '0;
          if (bit_cnt_reg == BIT_W'(DATA_W - 1)) begin
            word_done_next = 1'b1;
            word_src_next  = owner_reg;
            gnt_next       = '0;
            bit_cnt_next   = '0;
            state_next     = IDLE;
          end else begin
            bit_cnt_next = bit_cnt_reg + BIT_W'(1);
          end
        end else if (to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
          // Stalled source: drop the grant and resync the deserializer.
          gnt_next        = '0;
          abort_next      = 1'b1;
          deser_srst_next = 1'b1;
          state_next      = FLUSH;
        end else begin
          to_cnt_next = to_cnt_reg + TO_W'(1);
        end
      end
      FLUSH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign gnt_o            = gnt_reg;
  assign owner_o          = owner_reg;
  assign deser_data_o     = deser_data_reg;
  assign deser_data_val_o = deser_val_reg;
  assign deser_srst_o     = deser_srst_reg;
  assign word_done_o      = word_done_reg;
  assign word_src_o       = word_src_reg;
  assign abort_o          = abort_reg;

endmodule

// File: tb/tb_deser_rr_arbiter.sv
// Scoreboard bench for deser_rr_arbiter: expected bits and words are queued when
// driven and popped as the deserializer-side outputs appear.
module tb_deser_rr_arbiter;
  localparam int N_REQ   = 4;
  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic [N_REQ-1:0] din = '0;
  logic [N_REQ-1:0] dval = '0;
  logic [N_REQ-1:0] gnt_o;
  logic [1:0]       owner_o;
  logic             deser_data_o;
  logic             deser_data_val_o;
  logic             deser_srst_o;
  logic             word_done_o;
  logic [1:0]       word_src_o;
  logic             abort_o;

  always #5 clk = ~clk;

  deser_rr_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .req_i            (req),
    .data_i           (din),
    .data_val_i       (dval),
    .gnt_o            (gnt_o),
    .owner_o          (owner_o),
    .deser_data_o     (deser_data_o),
    .deser_data_val_o (deser_data_val_o),
    .deser_srst_o     (deser_srst_o),
    .word_done_o      (word_done_o),
    .word_src_o       (word_src_o),
    .abort_o          (abort_o)
  );

  int checks = 0;
  int errors = 0;
  logic        exp_bits[$];
  int          exp_src_q[$];
  logic [15:0] exp_word_q[$];
  logic [15:0] shreg = '0;
  int          nbits = 0;
  int          val_cnt = 0;
  int          abort_cnt = 0;
  int          srst_cnt = 0;
  logic        noise_en = 1'b0;
  int          noise_skip = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: sample outputs 1ns after the edge, score them, then update noise.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      nbits = 0;
      return;
    end
    if (deser_data_val_o) begin
      val_cnt++;
      if (exp_bits.size() == 0) check("bit_extra", 32'(deser_data_val_o), 32'(0));
      else check("bit", 32'(deser_data_o), 32'(exp_bits.pop_front()));
      shreg = {shreg[14:0], deser_data_o};
      nbits++;
    end
    if (word_done_o) begin
      if (exp_src_q.size() == 0) check("word_extra", 32'(word_done_o), 32'(0));
      else begin
        check("word_src", 32'(word_src_o), 32'(exp_src_q.pop_front()));
        check("word_data", 32'(shreg), 32'(exp_word_q.pop_front()));
        check("word_len", 32'(nbits), 32'(DATA_W));
      end
      nbits = 0;
    end
    if (abort_o) begin
      abort_cnt++;
      nbits = 0;
    end
    if (deser_srst_o) srst_cnt++;
    if (noise_en) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (i != noise_skip) begin
          din[i]  = 1'($urandom);
          dval[i] = 1'($urandom);
        end
      end
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({gnt_o, owner_o, deser_data_o, deser_data_val_o, deser_srst_o,
                word_done_o, word_src_o, abort_o});
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    din = '0;
    dval = '0;
    #1;
    check("rst_outs", all_outs(), 32'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_outs", all_outs(), 32'(0));
  endtask

  // Wait for src's grant, then send nsend bits of w MSB-first with gap idle cycles.
  task automatic run_grant(input int src, input logic [15:0] w, input int gap,
                           input int exp_wait, input int nsend);
    int n = 0;
    do begin
      tick();
      n++;
    end while (gnt_o == '0 && n < 50);
    if (gnt_o == '0) begin
      check("gnt_timeout", 32'(gnt_o), 32'(1 << src));
      return;
    end
    check("gnt", 32'(gnt_o), 32'(1 << src));
    check("owner", 32'(owner_o), 32'(src));
    if (exp_wait > 0) check("gnt_wait", 32'(n), 32'(exp_wait));
    req[src] = 1'b0;
    if (nsend == DATA_W) begin
      exp_src_q.push_back(src);
      exp_word_q.push_back(w);
    end
    for (int i = 0; i < nsend; i++) begin
      din[src]  = w[DATA_W-1-i];
      dval[src] = 1'b1;
      exp_bits.push_back(w[DATA_W-1-i]);
      tick();
      dval[src] = 1'b0;
      if (i < nsend - 1) repeat (gap) tick();
    end
    if (nsend == DATA_W) check("gnt_drop", 32'(gnt_o), 32'(0));
  endtask

  initial begin
    int n;
    int v0;
    do_reset();

    // Single source
    v0 = val_cnt;
    req = 4'b0001;
    run_grant(0, 16'hA5C3, 0, 1, DATA_W);
    check("val_pulses", 32'(val_cnt - v0), 32'(16));
    $display("single source word done, grant gap ok");

    // All four requesting: 0,1,2,3,0 with one-cycle gnt gaps
    do_reset();
    req = 4'b1111;
    run_grant(0, 16'h1234, 0, 1, DATA_W);
    req[0] = 1'b1;
    run_grant(1, 16'hBEEF, 0, 1, DATA_W);
    run_grant(2, 16'h0F0F, 0, 1, DATA_W);
    run_grant(3, 16'h8001, 0, 1, DATA_W);
    run_grant(0, 16'h7FFE, 0, 1, DATA_W);
    $display("round robin sequence complete");

    // Gapped valid bits, no abort
    req = 4'b0010;
    run_grant(1, 16'hC3A5, 3, 1, DATA_W);
    check("no_abort_gapped", 32'(abort_cnt), 32'(0));
    $display("gapped transfer complete");

    // Stall: source 2 sends 5 bits then stops; 3 and 0 wait their turn
    req = 4'b1101;
    run_grant(2, 16'hF00F, 0, 1, 5);
    n = 0;
    do begin
      tick();
      n++;
    end while (!abort_o && n < 30);
    check("abort_lat", 32'(n), 32'(TIMEOUT));
    check("srst_pulse", 32'(deser_srst_o), 32'(1));
    check("abort_gnt", 32'(gnt_o), 32'(0));
    check("abort_no_done", 32'(word_done_o), 32'(0));
    tick();
    check("flush_outs", 32'({abort_o, deser_srst_o, deser_data_val_o, gnt_o}), 32'(0));
    run_grant(3, 16'h5AA5, 0, 1, DATA_W);
    run_grant(0, 16'h0001, 0, 1, DATA_W);
    check("abort_cnt", 32'(abort_cnt), 32'(1));
    check("srst_cnt", 32'(srst_cnt), 32'(1));
    $display("stall abort and resume complete");

    // Interference from non-granted sources while source 2 owns the grant
    noise_skip = 2;
    noise_en = 1'b1;
    req = 4'b0100;
    run_grant(2, 16'h9C6B, 1, 1, DATA_W);
    noise_en = 1'b0;
    din = '0;
    dval = '0;
    tick();
    $display("interference transfer complete");

    // Reset mid-word
    req = 4'b0010;
    run_grant(1, 16'hFFFF, 0, 1, 7);
    check("midword_gnt", 32'(gnt_o), 32'(4'b0010));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", all_outs(), 32'(0));
    req = '0;
    din = '0;
    dval = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    req = 4'b0011;
    run_grant(0, 16'hA5C3, 0, 1, DATA_W);
    run_grant(1, 16'h3C3C, 0, 1, DATA_W);
    check("abort_cnt_end", 32'(abort_cnt), 32'(1));
    $display("reset mid-word and recovery complete");

    repeat (3) tick();
    check("bits_left", 32'(exp_bits.size()), 32'(0));
    check("words_left", 32'(exp_src_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
